// File: rtl/z80_fetch_unit.sv
// z80_fetch_unit: memory front end for the pipelined Z80 core.
// Owns the single A/DI/DO/W memory port. Opcode bytes are prefetched into a
// DEPTH-entry queue, and core data reads and writes are interleaved with
// priority over fetches. The memory may be pipelined with any fixed latency.
// Every issued access carries a tag down a MEM_LAT-deep shift register, so the
// tag and its DI byte leave the pipeline on the same edge. A queue slot is
// reserved when a fetch is issued, so the queue can never overflow.
module z80_fetch_unit #(
  parameter int              DEPTH    = 4,
  parameter int              MEM_LAT  = 2,
  parameter int              AW       = 16,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic          HOLD,
  output logic [AW-1:0] A,
  input  logic [7:0]    DI,
  output logic [7:0]    DO,
  output logic          W,
  input  logic          FLUSH,
  input  logic [AW-1:0] FLUSH_PC,
  output logic          Q_VALID,
  output logic [7:0]    Q_DATA,
  output logic [AW-1:0] Q_PC,
  input  logic          Q_POP,
  input  logic          D_REQ,
  input  logic          D_WE,
  input  logic [AW-1:0] D_ADDR,
  input  logic [7:0]    D_WDATA,
  output logic          D_BUSY,
  output logic          D_ACK,
  output logic [7:0]    D_RDATA
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // One in-flight access. Writes never enter the pipeline: their
  // acknowledge is derived from W alone.
  typedef struct packed {
    logic          valid;
    logic          is_fetch;
    logic [AW-1:0] pc;
  } tag_t;

  tag_t          tags [MEM_LAT];
  logic [7:0]    q_data_mem [DEPTH];
  logic [AW-1:0] q_pc_mem   [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [AW-1:0] fetch_pc;

  logic [CW-1:0] in_flight;
  logic          data_issue;
  logic          fetch_issue;
  tag_t          arrive;
  logic          arrive_data;
  logic          push;
  logic          pop;
  tag_t          issue_tag;

  // Count fetches still in the memory pipeline; together with count this
  // gives the number of queue slots already spoken for.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      if (tags[i].valid && tags[i].is_fetch) in_flight = in_flight + CW'(1);
    end
  end

  // Issue arbitration (data beats fetch) and queue push/pop decisions.
  always_comb begin
    data_issue  = D_REQ && !D_BUSY && HOLD;
    fetch_issue = HOLD && !data_issue && !FLUSH &&
                  (({1'b0, count} + {1'b0, in_flight}) < (CW + 1)'(DEPTH));
    arrive      = tags[MEM_LAT-1];
    arrive_data = arrive.valid && !arrive.is_fetch;
    push        = arrive.valid && arrive.is_fetch && !FLUSH;
    pop         = Q_POP && Q_VALID && !FLUSH;
    issue_tag.valid    = fetch_issue || (data_issue && !D_WE);
    issue_tag.is_fetch = fetch_issue;
    issue_tag.pc       = fetch_pc;
  end

  assign Q_VALID = (count != '0);
  assign Q_DATA  = q_data_mem[rd_ptr];
  assign Q_PC    = q_pc_mem[rd_ptr];

  // Registered memory port: address, write data and one-cycle write strobe.
  // With HOLD low nothing issues, so A keeps its last value and W drops.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      A  <= '0;
      DO <= '0;
      W  <= 1'b0;
    end else begin
      W <= 1'b0;
      if (data_issue) begin
        A <= D_ADDR;
        if (D_WE) begin
          DO <= D_WDATA;
          W  <= 1'b1;
        end
      end else if (fetch_issue) begin
        A <= fetch_pc;
      end
    end
  end

  // Next opcode fetch address; a redirect overrides any advance.
  always_ff @(posedge CLOCK) begin
    if (RESET)            fetch_pc <= RESET_PC;
    else if (FLUSH)       fetch_pc <= FLUSH_PC;
    else if (fetch_issue) fetch_pc <= fetch_pc + AW'(1);
  end

  // Tag shift register; a redirect kills fetch tags but lets data tags live.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      for (int i = 0; i < MEM_LAT; i++) tags[i] <= '0;
    end else begin
      tags[0] <= issue_tag;
      for (int i = 1; i < MEM_LAT; i++) begin
        tags[i]       <= tags[i-1];
        tags[i].valid <= tags[i-1].valid && !(FLUSH && tags[i-1].is_fetch);
      end
    end
  end

  // Queue storage: written on push only.
  // NOTE: the storage array is deliberately not reset; count gates every
  // read, so stale entries are never observed and reset stays cheap.
  always_ff @(posedge CLOCK) begin
    if (push) begin
      q_data_mem[wr_ptr] <= DI;
      q_pc_mem[wr_ptr]   <= arrive.pc;
    end
  end

  // Queue pointers and occupancy; a simultaneous push and pop leaves count alone.
  always_ff @(posedge CLOCK) begin
    if (RESET || FLUSH) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Data side handshake. A write completes one edge after W; a read
  // completes when its tag leaves the pipeline with DI.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      D_BUSY  <= 1'b0;
      D_ACK   <= 1'b0;
      D_RDATA <= '0;
    end else begin
      D_ACK <= W || arrive_data;
      if (arrive_data) D_RDATA <= DI;
      if (data_issue)  D_BUSY  <= 1'b1;
      else if (D_ACK)  D_BUSY  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_z80_fetch_unit.sv
// Directed bench for z80_fetch_unit with DEPTH=4, MEM_LAT=2, RESET_PC=0.
// The memory returns mem[a] = a[7:0] ^ 8'h5A, with DI reflecting the address
// registered one edge earlier, so a byte is sampled two edges after A.
module tb_z80_fetch_unit;

  logic        CLOCK;
  logic        RESET;
  logic        HOLD;
  logic [15:0] A;
  logic [7:0]  DI;
  logic [7:0]  DO;
  logic        W;
  logic        FLUSH;
  logic [15:0] FLUSH_PC;
  logic        Q_VALID;
  logic [7:0]  Q_DATA;
  logic [15:0] Q_PC;
  logic        Q_POP;
  logic        D_REQ;
  logic        D_WE;
  logic [15:0] D_ADDR;
  logic [7:0]  D_WDATA;
  logic        D_BUSY;
  logic        D_ACK;
  logic [7:0]  D_RDATA;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] a_d = '0;
  logic [15:0] exp_pc;
  logic [15:0] mark;

  z80_fetch_unit #(
    .DEPTH(4), .MEM_LAT(2), .AW(16), .RESET_PC(16'h0000)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .HOLD(HOLD), .A(A), .DI(DI), .DO(DO), .W(W),
    .FLUSH(FLUSH), .FLUSH_PC(FLUSH_PC), .Q_VALID(Q_VALID), .Q_DATA(Q_DATA),
    .Q_PC(Q_PC), .Q_POP(Q_POP), .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR),
    .D_WDATA(D_WDATA), .D_BUSY(D_BUSY), .D_ACK(D_ACK), .D_RDATA(D_RDATA)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  function automatic logic [7:0] mem_f(input logic [15:0] addr);
    return addr[7:0] ^ 8'h5A;
  endfunction

  // Two-edge memory: address pipeline stage, then combinational array read.
  always @(posedge CLOCK) a_d <= A;
  assign DI = mem_f(a_d);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  // One edge while streaming: a popped head must be the next byte in order.
  task automatic step_stream();
    if (Q_POP && Q_VALID) begin
      check("stream_pc", 32'(Q_PC), 32'(exp_pc));
      check("stream_data", 32'(Q_DATA), 32'(mem_f(exp_pc)));
      exp_pc = exp_pc + 16'd1;
    end
    step();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_A"}, 32'(A), 32'h0);
    check({tag, "_DO"}, 32'(DO), 32'h0);
    check({tag, "_W"}, 32'(W), 32'h0);
    check({tag, "_Q_VALID"}, 32'(Q_VALID), 32'h0);
    check({tag, "_D_BUSY"}, 32'(D_BUSY), 32'h0);
    check({tag, "_D_ACK"}, 32'(D_ACK), 32'h0);
    check({tag, "_D_RDATA"}, 32'(D_RDATA), 32'h0);
  endtask

  initial begin
    RESET = 1'b1; HOLD = 1'b1; FLUSH = 1'b0; FLUSH_PC = '0; Q_POP = 1'b0;
    D_REQ = 1'b0; D_WE = 1'b0; D_ADDR = '0; D_WDATA = '0;
    exp_pc = '0;
    step();
    step();
    check_reset_state("reset");

    // 1: fill from reset, four fetches then A holds; head valid on edge 3.
    RESET = 1'b0;
    step(); check("fill_A0", 32'(A), 32'h0); check("fill_v1", 32'(Q_VALID), 32'h0);
    step(); check("fill_A1", 32'(A), 32'h1); check("fill_v2", 32'(Q_VALID), 32'h0);
    step(); check("fill_A2", 32'(A), 32'h2); check("fill_v3", 32'(Q_VALID), 32'h1);
    check("fill_head_pc", 32'(Q_PC), 32'h0); check("fill_head_data", 32'(Q_DATA), 32'h5A);
    step(); check("fill_A3", 32'(A), 32'h3);
    step(); check("fill_hold5", 32'(A), 32'h3);
    step(); check("fill_hold6", 32'(A), 32'h3);
    step(); check("fill_hold7", 32'(A), 32'h3);

    // 2: continuous pop, one byte per cycle with no gaps.
    Q_POP = 1'b1;
    for (int i = 0; i < 32; i++) begin
      check("stream2_valid", 32'(Q_VALID), 32'h1);
      check("stream2_pc", 32'(Q_PC), 32'(i));
      check("stream2_data", 32'(Q_DATA), 32'(mem_f(16'(i))));
      step();
    end

    // 3: redirect with two fetches in flight; no stale byte may surface.
    Q_POP = 1'b0; FLUSH = 1'b1; FLUSH_PC = 16'h1234;
    step();
    FLUSH = 1'b0;
    check("flush_v0", 32'(Q_VALID), 32'h0);
    step(); check("flush_A", 32'(A), 32'h1234); check("flush_v1", 32'(Q_VALID), 32'h0);
    step(); check("flush_v2", 32'(Q_VALID), 32'h0);
    step(); check("flush_v3", 32'(Q_VALID), 32'h1);
    check("flush_head_pc", 32'(Q_PC), 32'h1234); check("flush_head_data", 32'(Q_DATA), 32'h6E);
    exp_pc = 16'h1234; Q_POP = 1'b1;
    for (int i = 0; i < 4; i++) step_stream();

    // 4: write while streaming; fetch resumes at the skipped address.
    mark = exp_pc;
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 16'h8000; D_WDATA = 8'hA5;
    step_stream();
    check("wr_A", 32'(A), 32'h8000); check("wr_W", 32'(W), 32'h1);
    check("wr_DO", 32'(DO), 32'hA5); check("wr_busy", 32'(D_BUSY), 32'h1);
    check("wr_ack_early", 32'(D_ACK), 32'h0);
    step_stream();
    check("wr_ack", 32'(D_ACK), 32'h1); check("wr_W_drop", 32'(W), 32'h0);
    check("wr_busy_ack", 32'(D_BUSY), 32'h1); check("wr_resume_A", 32'(A), 32'(mark + 16'd3));
    D_REQ = 1'b0; D_WE = 1'b0;
    step_stream();
    check("wr_ack_done", 32'(D_ACK), 32'h0); check("wr_busy_done", 32'(D_BUSY), 32'h0);
    for (int i = 0; i < 3; i++) step_stream();

    // 5: read while streaming; data arrives two edges after A.
    D_REQ = 1'b1; D_ADDR = 16'h4000;
    step_stream();
    check("rd_A", 32'(A), 32'h4000); check("rd_busy", 32'(D_BUSY), 32'h1);
    check("rd_ack0", 32'(D_ACK), 32'h0); check("rd_W", 32'(W), 32'h0);
    step_stream(); check("rd_ack1", 32'(D_ACK), 32'h0);
    step_stream();
    check("rd_ack2", 32'(D_ACK), 32'h1); check("rd_data", 32'(D_RDATA), 32'(mem_f(16'h4000)));
    D_REQ = 1'b0;
    step_stream();
    check("rd_ack_done", 32'(D_ACK), 32'h0); check("rd_busy_done", 32'(D_BUSY), 32'h0);
    for (int i = 0; i < 4; i++) step_stream();
    check("stream_progress", 32'((exp_pc - mark) >= 16'd10), 32'h1);

    // 6: reset with the queue full and a read in flight.
    Q_POP = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("full_valid", 32'(Q_VALID), 32'h1);
    D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 16'h4000;
    step();
    check("rst_rd_A", 32'(A), 32'h4000); check("rst_rd_busy", 32'(D_BUSY), 32'h1);
    RESET = 1'b1; D_REQ = 1'b0;
    step();
    check_reset_state("midrst");
    RESET = 1'b0;
    step(); check("post_A0", 32'(A), 32'h0); check("post_ack0", 32'(D_ACK), 32'h0);
    step(); check("post_A1", 32'(A), 32'h1); check("post_ack1", 32'(D_ACK), 32'h0);

    // HOLD low: A holds, W stays low, in-flight fetches still land.
    HOLD = 1'b0;
    step(); check("hold_A", 32'(A), 32'h1); check("hold_W", 32'(W), 32'h0);
    check("hold_valid", 32'(Q_VALID), 32'h1); check("hold_ack", 32'(D_ACK), 32'h0);
    check("hold_head", 32'(Q_DATA), 32'h5A);
    step(); check("hold_A2", 32'(A), 32'h1);
    HOLD = 1'b1;
    step(); check("unhold_A", 32'(A), 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
